reindeer_fetch_prefetch_queue: RTL and testbench

//  Parametrised instruction prefetch unit that replaces the single-word fetcher between the scheduler and the memory controller.

---
 rtl/reindeer_fetch_prefetch_queue.sv | 123 ++++++++++++
 tb/tb_reindeer_fetch_prefetch_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reindeer_fetch_prefetch_queue.sv
// Instruction prefetch unit: keeps several reads in flight and queues the returned words in order.
// A redirect or soft reset flushes the queue and discards responses that were still in flight.
module reindeer_fetch_prefetch_queue #(
  parameter int XLEN            = 32,
  parameter int PC_BITWIDTH     = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset,
  input  logic                   fetch_init,
  input  logic [PC_BITWIDTH-1:0] start_addr,
  input  logic                   fetch_next,
  output logic                   fetch_enable_out,
  output logic [XLEN-1:0]        IR_out,
  output logic [PC_BITWIDTH-1:0] PC_out,
  output logic                   read_mem_enable,
  output logic [PC_BITWIDTH-1:0] read_mem_addr,
  input  logic                   mem_read_done,
  input  logic [XLEN-1:0]        mem_data,
  input  logic                   dram_rw_pending
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_next;
  logic [PC_BITWIDTH-1:0] issue_addr, rsp_pc;
  logic [OUT_W-1:0]       outstanding, outstanding_next, drop_cnt, drop_next;
  logic [CNT_W-1:0]       count, count_next;
  logic [PTR_W-1:0]       head, tail;
  logic [XLEN-1:0]        ir_mem [FIFO_DEPTH];
  logic [PC_BITWIDTH-1:0] pc_mem [FIFO_DEPTH];
  logic                   flush, issue, push, pop, space_ok;
  logic [CNT_W:0]         in_use;

  // Queue space is reserved per issued request, net of responses that will be dropped.
  always_comb begin
    state_next = state;
    flush      = sync_reset || fetch_init;
    if (sync_reset)      state_next = IDLE;
    else if (fetch_init) state_next = RUN;

    in_use   = (CNT_W+1)'(count) + (CNT_W+1)'(outstanding) - (CNT_W+1)'(drop_cnt);
    space_ok = in_use < (CNT_W+1)'(FIFO_DEPTH);
    issue    = (state == RUN) && !flush && !dram_rw_pending &&
               (outstanding < OUT_W'(MAX_OUTSTANDING)) && space_ok;
    push     = mem_read_done && (drop_cnt == '0) && !flush;
    pop      = fetch_next && (count != '0) && !flush;

    outstanding_next = outstanding;
    if (issue && !mem_read_done)
      outstanding_next = outstanding + OUT_W'(1);
    else if (!issue && mem_read_done && (outstanding != '0))
      outstanding_next = outstanding - OUT_W'(1);

    drop_next = drop_cnt;
    if (flush)
      drop_next = outstanding_next;
    else if (mem_read_done && (drop_cnt != '0))
      drop_next = drop_cnt - OUT_W'(1);

    count_next = count;
    if (flush)              count_next = '0;
    else if (push && !pop)  count_next = count + CNT_W'(1);
    else if (pop && !push)  count_next = count - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      issue_addr      <= '0;
      rsp_pc          <= '0;
      outstanding     <= '0;
      drop_cnt        <= '0;
      count           <= '0;
      head            <= '0;
      tail            <= '0;
      read_mem_enable <= 1'b0;
      read_mem_addr   <= '0;
    end else begin
      state           <= state_next;
      outstanding     <= outstanding_next;
      drop_cnt        <= drop_next;
      count           <= count_next;
      read_mem_enable <= issue;
      if (issue) begin
        read_mem_addr <= issue_addr;
        issue_addr    <= issue_addr + PC_BITWIDTH'(4);
      end
      if (fetch_init && !sync_reset) begin
        issue_addr <= start_addr;
        rsp_pc     <= start_addr;
      end else if (push) begin
        rsp_pc <= rsp_pc + PC_BITWIDTH'(4);
      end
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
      end
    end
  end

  // Entry storage carries no reset; the outputs are gated by the occupancy count instead.
  always_ff @(posedge clk) begin
    if (push) begin
      ir_mem[tail] <= mem_data;
      pc_mem[tail] <= rsp_pc;
    end
  end

  assign fetch_enable_out = (count != '0);
  assign IR_out           = fetch_enable_out ? ir_mem[head] : '0;
  assign PC_out           = fetch_enable_out ? pc_mem[head] : '0;

endmodule

// File: tb/tb_reindeer_fetch_prefetch_queue.sv
// Directed bench for the prefetch queue: a vector table for streaming and issue stall,
// plus hand-written sequences for backpressure, redirect, soft reset and address wrap.
module tb_reindeer_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sync_reset;
  logic        fetch_init;
  logic [31:0] start_addr;
  logic        fetch_next;
  logic        fetch_enable_out;
  logic [31:0] IR_out;
  logic [31:0] PC_out;
  logic        read_mem_enable;
  logic [31:0] read_mem_addr;
  logic        mem_read_done;
  logic [31:0] mem_data;
  logic        dram_rw_pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 0;
  int req_count = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } mem_req_t;
  mem_req_t mq[$];

  typedef struct packed {
    logic        fi;
    logic [31:0] sa;
    logic        fn;
    logic        dr;
    logic        fen;
    logic [31:0] pc;
    logic        ren;
    logic [31:0] raddr;
  } vec_t;
  vec_t vecs[13];

  reindeer_fetch_prefetch_queue #(
    .XLEN(32), .PC_BITWIDTH(32), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .fetch_init(fetch_init),
    .start_addr(start_addr), .fetch_next(fetch_next), .fetch_enable_out(fetch_enable_out),
    .IR_out(IR_out), .PC_out(PC_out), .read_mem_enable(read_mem_enable),
    .read_mem_addr(read_mem_addr), .mem_read_done(mem_read_done), .mem_data(mem_data),
    .dram_rw_pending(dram_rw_pending)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: memory model records the visible request pulse and answers in order after mem_lat cycles.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (read_mem_enable === 1'b1) begin
      req_count++;
      mq.push_back('{addr: read_mem_addr, due: 32'(cyc + mem_lat)});
    end
    if (mq.size() > 0 && int'(mq[0].due) <= cyc) begin
      mem_read_done = 1'b1;
      mem_data      = mem_fn(mq[0].addr);
      mq.delete(0);
    end else begin
      mem_read_done = 1'b0;
      mem_data      = '0;
    end
  endtask

  task automatic apply_stimulus(input logic fi, input logic [31:0] sa, input logic fn, input logic dr);
    fetch_init      = fi;
    start_addr      = sa;
    fetch_next      = fn;
    dram_rw_pending = dr;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    sync_reset    = 1'b0;
    mem_read_done = 1'b0;
    mem_data      = '0;
    mq.delete();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset fetch_enable_out", 32'(fetch_enable_out), 32'h0);
    check_output("reset IR_out", IR_out, 32'h0);
    check_output("reset PC_out", PC_out, 32'h0);
    check_output("reset read_mem_enable", 32'(read_mem_enable), 32'h0);
    check_output("reset read_mem_addr", read_mem_addr, 32'h0);
    reset_n   = 1'b1;
    cyc       = 0;
    req_count = 0;
  endtask

  task automatic wait_for_valid(input string name, input logic [31:0] exp_pc);
    for (int i = 0; i < 30 && fetch_enable_out !== 1'b1; i++) step();
    check_output({name, " valid within bound"}, 32'(fetch_enable_out), 32'h1);
    check_output({name, " first PC_out"}, PC_out, exp_pc);
    check_output({name, " first IR_out"}, IR_out, mem_fn(exp_pc));
  endtask

  initial begin
    // Streaming from 0x100 with a same-cycle memory, then five cycles of issue stall.
    vecs = '{
      '{fi:1, sa:32'h100, fn:1, dr:0, fen:0, pc:32'h0,   ren:0, raddr:32'h0},
      '{fi:0, sa:32'h0,   fn:1, dr:0, fen:0, pc:32'h0,   ren:1, raddr:32'h100},
      '{fi:0, sa:32'h0,   fn:1, dr:0, fen:1, pc:32'h100, ren:1, raddr:32'h104},
      '{fi:0, sa:32'h0,   fn:1, dr:0, fen:1, pc:32'h104, ren:1, raddr:32'h108},
      '{fi:0, sa:32'h0,   fn:1, dr:0, fen:1, pc:32'h108, ren:1, raddr:32'h10C},
      '{fi:0, sa:32'h0,   fn:1, dr:1, fen:1, pc:32'h10C, ren:0, raddr:32'h0},
      '{fi:0, sa:32'h0,   fn:1, dr:1, fen:0, pc:32'h0,   ren:0, raddr:32'h0},
      '{fi:0, sa:32'h0,   fn:1, dr:1, fen:0, pc:32'h0,   ren:0, raddr:32'h0},
      '{fi:0, sa:32'h0,   fn:1, dr:1, fen:0, pc:32'h0,   ren:0, raddr:32'h0},
      '{fi:0, sa:32'h0,   fn:1, dr:1, fen:0, pc:32'h0,   ren:0, raddr:32'h0},
      '{fi:0, sa:32'h0,   fn:1, dr:0, fen:0, pc:32'h0,   ren:1, raddr:32'h110},
      '{fi:0, sa:32'h0,   fn:1, dr:0, fen:1, pc:32'h110, ren:1, raddr:32'h114},
      '{fi:0, sa:32'h0,   fn:1, dr:0, fen:1, pc:32'h114, ren:1, raddr:32'h118}
    };

    do_reset();
    mem_lat = 0;
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].fi, vecs[i].sa, vecs[i].fn, vecs[i].dr);
      step();
      check_output($sformatf("vec%0d fetch_enable_out", i), 32'(fetch_enable_out), 32'(vecs[i].fen));
      check_output($sformatf("vec%0d read_mem_enable", i), 32'(read_mem_enable), 32'(vecs[i].ren));
      if (vecs[i].ren)
        check_output($sformatf("vec%0d read_mem_addr", i), read_mem_addr, vecs[i].raddr);
      if (vecs[i].fen) begin
        check_output($sformatf("vec%0d PC_out", i), PC_out, vecs[i].pc);
        check_output($sformatf("vec%0d IR_out", i), IR_out, mem_fn(vecs[i].pc));
      end
    end

    // Backpressure: with no consumption exactly FIFO_DEPTH reads go out and the head holds.
    do_reset();
    mem_lat = 0;
    apply_stimulus(1'b1, 32'h100, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (20) step();
    check_output("full request count", 32'(req_count), 32'd4);
    check_output("full read_mem_enable", 32'(read_mem_enable), 32'h0);
    check_output("full fetch_enable_out", 32'(fetch_enable_out), 32'h1);
    check_output("full PC_out", PC_out, 32'h100);
    check_output("full IR_out", IR_out, mem_fn(32'h100));

    // Redirect with two reads in flight: both stale responses must be discarded.
    do_reset();
    mem_lat = 4;
    apply_stimulus(1'b1, 32'h100, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) step();
    check_output("redirect pre fetch_enable_out", 32'(fetch_enable_out), 32'h0);
    check_output("redirect pre request count", 32'(req_count), 32'd2);
    apply_stimulus(1'b1, 32'h200, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    wait_for_valid("redirect", 32'h200);

    // Soft reset with one read in flight, an idle cycle, then a redirect to 0x40.
    do_reset();
    mem_lat = 4;
    apply_stimulus(1'b1, 32'h100, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check_output("sreset first read_mem_addr", read_mem_addr, 32'h100);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check_output("sreset idle read_mem_enable", 32'(read_mem_enable), 32'h0);
    check_output("sreset idle fetch_enable_out", 32'(fetch_enable_out), 32'h0);
    apply_stimulus(1'b1, 32'h40, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    wait_for_valid("sreset", 32'h40);

    // Address wrap, then push and pop together at FIFO_DEPTH-1 entries.
    do_reset();
    mem_lat = 0;
    apply_stimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check_output("wrap first read_mem_addr", read_mem_addr, 32'hFFFF_FFFC);
    step();
    check_output("wrap second read_mem_addr", read_mem_addr, 32'h0);
    step();
    step();
    check_output("wrap head PC_out", PC_out, 32'hFFFF_FFFC);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
    step();
    check_output("pushpop PC_out", PC_out, 32'h0);
    check_output("pushpop read_mem_enable", 32'(read_mem_enable), 32'h0);
    step();
    check_output("drain1 PC_out", PC_out, 32'h4);
    step();
    check_output("drain2 PC_out", PC_out, 32'h8);
    check_output("drain2 IR_out", IR_out, mem_fn(32'h8));
    step();
    check_output("drain3 fetch_enable_out", 32'(fetch_enable_out), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
